lcd_ctrl: RTL and testbench

HD44780-style character LCD controller between the LSU LCD I/O register and the LCD pins. After reset it runs the power-up initialisation sequence on its own. It then accepts one command byte or data byte at a time from the CPU side through a valid/ready handshake. For each byte it generates the RS/DATA setup, the EN pulse, the hold time and the post-write wait with cycle-accurate timing.

---
 rtl/lcd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller: runs the power-up init sequence,
// then writes one CPU command/data byte per valid/ready handshake with exact EN timing.
module lcd_ctrl #(
  parameter int P_POWERUP_CYC   = 750000,
  parameter int P_SETUP_CYC     = 2,
  parameter int P_EN_CYC        = 12,
  parameter int P_HOLD_CYC      = 2,
  parameter int P_WAIT_CYC      = 2500,
  parameter int P_LONG_WAIT_CYC = 82000,
  parameter int P_CNT_W         = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_rdy,
  output logic       o_init_done,
  output logic       o_busy,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  typedef enum logic [2:0] {
    S_POWERUP, S_LOAD, S_SETUP, S_EN_HIGH, S_HOLD, S_WAIT, S_IDLE
  } state_t;

  localparam logic [P_CNT_W-1:0] L_POWERUP   = P_CNT_W'(P_POWERUP_CYC - 1);
  localparam logic [P_CNT_W-1:0] L_SETUP     = P_CNT_W'(P_SETUP_CYC - 1);
  localparam logic [P_CNT_W-1:0] L_EN        = P_CNT_W'(P_EN_CYC - 1);
  localparam logic [P_CNT_W-1:0] L_HOLD      = P_CNT_W'(P_HOLD_CYC - 1);
  localparam logic [P_CNT_W-1:0] L_WAIT      = P_CNT_W'(P_WAIT_CYC - 1);
  localparam logic [P_CNT_W-1:0] L_LONG_WAIT = P_CNT_W'(P_LONG_WAIT_CYC - 1);
  localparam logic [P_CNT_W-1:0] L_ONE       = P_CNT_W'(1);
  localparam logic [2:0]         L_LAST_INIT = 3'd5;

  state_t             r_state;
  logic [P_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic               r_init_done;
  logic               r_req_rdy;
  logic               r_busy;
  logic               r_lcd_on;
  logic               r_lcd_en;
  logic               r_lcd_rs;
  logic [7:0]         r_lcd_data;
  logic               r_req_rs;
  logic [7:0]         r_req_data;

  logic [7:0]         w_rom_data;
  logic               w_cnt_zero;
  logic               w_long_wait;

  // NOTE: the default arm assigns every path, so no latch is inferred.
  always_comb begin
    case (r_idx)
      3'd0, 3'd1, 3'd2: w_rom_data = 8'h38;
      3'd3:             w_rom_data = 8'h0C;
      3'd4:             w_rom_data = 8'h01;
      default:          w_rom_data = 8'h06;
    endcase
  end

  assign w_cnt_zero = (r_cnt == '0);
  // Clear (0x01) and return-home (0x02/0x03) take far longer to execute in the LCD.
  assign w_long_wait = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data[1:0] != 2'd0);

  // NOTE: non-blocking assignments everywhere here so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_POWERUP;
      r_cnt       <= L_POWERUP;
      r_idx       <= '0;
      r_init_done <= 1'b0;
      r_req_rdy   <= 1'b0;
      r_busy      <= 1'b0;
      r_lcd_on    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= '0;
      r_req_rs    <= 1'b0;
      r_req_data  <= '0;
    end else begin
      r_lcd_on <= 1'b1;
      case (r_state)
        S_POWERUP: begin
          r_busy <= 1'b1;
          if (w_cnt_zero) r_state <= S_LOAD;
          else            r_cnt   <= r_cnt - L_ONE;
        end
        S_LOAD: begin
          r_lcd_rs   <= r_init_done ? r_req_rs   : 1'b0;
          r_lcd_data <= r_init_done ? r_req_data : w_rom_data;
          r_cnt      <= L_SETUP;
          r_state    <= S_SETUP;
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_lcd_en <= 1'b1;
            r_cnt    <= L_EN;
            r_state  <= S_EN_HIGH;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_EN_HIGH: begin
          if (w_cnt_zero) begin
            r_lcd_en <= 1'b0;
            r_cnt    <= L_HOLD;
            r_state  <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            r_cnt   <= w_long_wait ? L_LONG_WAIT : L_WAIT;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_WAIT: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - L_ONE;
          end else if (!r_init_done && r_idx != L_LAST_INIT) begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_LOAD;
          end else begin
            r_init_done <= 1'b1;
            r_req_rdy   <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (i_req_vld && r_req_rdy) begin
            r_req_rs   <= i_req_rs;
            r_req_data <= i_req_data;
            r_req_rdy  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        default: r_state <= S_POWERUP;
      endcase
    end
  end

  assign o_req_rdy   = r_req_rdy;
  assign o_init_done = r_init_done;
  assign o_busy      = r_busy;
  assign o_lcd_on    = r_lcd_on;
  assign o_lcd_en    = r_lcd_en;
  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: cycle-by-cycle comparison against a timeline
// model of the LCD write protocol, plus latency vectors and reset/back-to-back sequences.
module tb_lcd_ctrl;

  localparam int P_POWERUP_CYC   = 20;
  localparam int P_SETUP_CYC     = 2;
  localparam int P_EN_CYC        = 3;
  localparam int P_HOLD_CYC      = 2;
  localparam int P_WAIT_CYC      = 5;
  localparam int P_LONG_WAIT_CYC = 40;
  localparam int P_CNT_W         = 20;
  localparam int P_TXN_BASE      = 1 + P_SETUP_CYC + P_EN_CYC + P_HOLD_CYC;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_req_vld = 1'b0;
  logic       i_req_rs = 1'b0;
  logic [7:0] i_req_data = 8'h00;
  logic       o_req_rdy, o_init_done, o_busy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl #(
    .P_POWERUP_CYC  (P_POWERUP_CYC),
    .P_SETUP_CYC    (P_SETUP_CYC),
    .P_EN_CYC       (P_EN_CYC),
    .P_HOLD_CYC     (P_HOLD_CYC),
    .P_WAIT_CYC     (P_WAIT_CYC),
    .P_LONG_WAIT_CYC(P_LONG_WAIT_CYC),
    .P_CNT_W        (P_CNT_W)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req_vld  (i_req_vld),
    .i_req_rs   (i_req_rs),
    .i_req_data (i_req_data),
    .o_req_rdy  (o_req_rdy),
    .o_init_done(o_init_done),
    .o_busy     (o_busy),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {logic rs; logic [7:0] data;} wr_t;
  typedef struct {logic rs; logic [7:0] data; int latency;} vec_t;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Timeline model: each write is a LOAD cycle m_L followed by fixed-length phases.
  bit         m_active, m_idle, m_init_done;
  int         m_idx, m_L, m_end;
  logic       m_rs, m_prs;
  logic [7:0] m_data, m_pdata;
  logic [7:0] init_rom [6];
  wr_t        exp_q[$];
  wr_t        obs_q[$];
  bit         accepted;
  int         n_acc;
  logic       prev_en;
  int         first_en;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, n);
  endtask

  function automatic int wait_len(logic rs, logic [7:0] d);
    if (rs == 1'b0 && d inside {8'h01, 8'h02, 8'h03}) return P_LONG_WAIT_CYC;
    return P_WAIT_CYC;
  endfunction

  task automatic start_txn(int load_cyc, logic rs, logic [7:0] d);
    m_active = 1'b1;
    m_idle   = 1'b0;
    m_L      = load_cyc;
    m_rs     = rs;
    m_data   = d;
    m_end    = load_cyc + P_TXN_BASE + wait_len(rs, d);
    exp_q.push_back({rs, d});
  endtask

  task automatic model_reset();
    n           = 0;
    m_init_done = 1'b0;
    m_idx       = 0;
    m_prs       = 1'b0;
    m_pdata     = 8'h00;
    prev_en     = 1'b0;
    first_en    = -1;
    start_txn(P_POWERUP_CYC, 1'b0, init_rom[0]);
  endtask

  task automatic model_update();
    if (m_active && n == m_end) begin
      m_prs    = m_rs;
      m_pdata  = m_data;
      m_active = 1'b0;
      if (!m_init_done && m_idx < 5) begin
        m_idx++;
        start_txn(n, 1'b0, init_rom[m_idx]);
      end else begin
        m_init_done = 1'b1;
        m_idle      = 1'b1;
      end
    end
  endtask

  // Compare one cycle of outputs, then advance to the next negedge.
  task automatic tick();
    bit         e_en;
    logic       e_rs;
    logic [7:0] e_data;
    model_update();
    e_en = m_active && (n >= m_L + P_SETUP_CYC + 1) && (n <= m_L + P_SETUP_CYC + P_EN_CYC);
    if (m_active && n >= m_L + 1) begin
      e_rs = m_rs; e_data = m_data;
    end else begin
      e_rs = m_prs; e_data = m_pdata;
    end
    check("lcd_on",    32'(o_lcd_on),    32'(n >= 1));
    check("busy",      32'(o_busy),      32'(n >= 1 && !m_idle));
    check("req_rdy",   32'(o_req_rdy),   32'(m_idle));
    check("init_done", 32'(o_init_done), 32'(m_init_done));
    check("lcd_en",    32'(o_lcd_en),    32'(e_en));
    check("lcd_rs",    32'(o_lcd_rs),    32'(e_rs));
    check("lcd_data",  32'(o_lcd_data),  32'(e_data));
    check("lcd_rw",    32'(o_lcd_rw),    32'(0));
    if (o_lcd_en === 1'b1 && prev_en !== 1'b1) begin
      obs_q.push_back({o_lcd_rs, o_lcd_data});
      if (first_en < 0) first_en = n;
    end
    prev_en  = o_lcd_en;
    accepted = 1'b0;
    if (m_idle && i_req_vld) begin
      accepted = 1'b1;
      n_acc    = n;
      start_txn(n + 1, i_req_rs, i_req_data);
    end
    @(negedge i_clk);
    n++;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rdy"},  32'(o_req_rdy),   32'(0));
    check({tag, "_init"}, 32'(o_init_done), 32'(0));
    check({tag, "_busy"}, 32'(o_busy),      32'(0));
    check({tag, "_on"},   32'(o_lcd_on),    32'(0));
    check({tag, "_en"},   32'(o_lcd_en),    32'(0));
    check({tag, "_rs"},   32'(o_lcd_rs),    32'(0));
    check({tag, "_rw"},   32'(o_lcd_rw),    32'(0));
    check({tag, "_data"}, 32'(o_lcd_data),  32'(0));
  endtask

  task automatic do_reset(int cycles);
    i_reset = 1'b0;
    repeat (cycles) begin
      @(negedge i_clk);
      check_all_zero("reset");
    end
    i_reset = 1'b1;
    model_reset();
  endtask

  task automatic run_until_idle(string name, int budget);
    int k = 0;
    while (!m_idle && k < budget) begin
      tick();
      k++;
    end
    if (!m_idle) timeout(name);
  endtask

  // Present a request and hold it until the model sees it accepted.
  task automatic send(logic rs, logic [7:0] d, int budget);
    int k = 0;
    i_req_vld  = 1'b1;
    i_req_rs   = rs;
    i_req_data = d;
    accepted   = 1'b0;
    while (!accepted && k < budget) begin
      tick();
      k++;
    end
    if (!accepted) timeout($sformatf("accept_%02h", d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    int   k;
    init_rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    vecs[0] = '{1'b1, 8'h41, 13};
    vecs[1] = '{1'b0, 8'h01, 48};
    vecs[2] = '{1'b0, 8'h80, 13};
    vecs[3] = '{1'b0, 8'h02, 48};
    vecs[4] = '{1'b0, 8'h03, 48};
    vecs[5] = '{1'b0, 8'h00, 13};
    vecs[6] = '{1'b0, 8'h04, 13};
    vecs[7] = '{1'b1, 8'h01, 13};
    vecs[8] = '{1'b1, 8'h02, 13};

    // Reset and power-up init
    #1 i_reset = 1'b0;
    do_reset(10);
    run_until_idle("init", 500);
    check("first_en_rise", 32'(first_en), 32'(P_POWERUP_CYC + 1 + P_SETUP_CYC));
    check("init_done_end", 32'(o_init_done), 32'(1));

    // Latency vectors: accept edge to ready returning
    foreach (vecs[i]) begin
      send(vecs[i].rs, vecs[i].data, 200);
      i_req_vld = 1'b0;
      k = 0;
      while (o_req_rdy !== 1'b1 && k < 200) begin
        tick();
        k++;
      end
      if (o_req_rdy !== 1'b1) timeout($sformatf("latency[%0d]", i));
      else check($sformatf("latency[%0d]", i), 32'(n - n_acc - 1), 32'(vecs[i].latency));
    end

    // Back-to-back held requests
    send(1'b1, 8'h48, 200);
    send(1'b1, 8'h49, 200);
    i_req_vld = 1'b0;
    run_until_idle("b2b_idle", 200);

    // Randomised traffic, biased toward the long-wait command codes
    for (int r = 0; r < 40; r++) begin
      logic       rs_r;
      logic [7:0] d_r;
      int         gap;
      gap  = int'($urandom_range(0, 3));
      rs_r = 1'($urandom_range(0, 1));
      d_r  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      repeat (gap) tick();
      send(rs_r, d_r, 200);
      i_req_vld = 1'b0;
    end
    run_until_idle("rand_idle", 200);

    // Asynchronous reset in the middle of an EN pulse
    send(1'b1, 8'h5A, 200);
    i_req_vld = 1'b0;
    k = 0;
    while (n < m_L + P_SETUP_CYC + 2 && k < 50) begin
      tick();
      k++;
    end
    check("en_before_reset", 32'(o_lcd_en), 32'(1));
    #2 i_reset = 1'b0;
    #1 check_all_zero("async_reset");
    do_reset(5);

    // Requests held during init must wait for init_done
    send(1'b1, 8'h48, 400);
    check("held_accept_after_init", 32'(m_idx), 32'(5));
    send(1'b1, 8'h49, 200);
    i_req_vld = 1'b0;
    run_until_idle("final_idle", 200);
    check("first_en_rise_2", 32'(first_en), 32'(P_POWERUP_CYC + 1 + P_SETUP_CYC));

    // Every EN pulse carried the right byte, in order
    check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("write[%0d]", i), 32'(obs_q[i]), 32'(exp_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
